// File: rtl/adder_tree_pkg.sv
// Shared constants and state encoding for the adder-tree loader and its result FIFO.
// The tree itself is external; these values must match the instantiated tree.
package adder_tree_pkg;

  localparam int W         = 8;   // operand and sum width
  localparam int LANES     = 8;   // operands per frame
  localparam int TREE_LAT  = 3;   // tree input sample to output register update
  localparam int RES_DEPTH = 4;   // result FIFO depth == total launch credits
  localparam int CNT_W     = 16;  // launched-frame counter width

  typedef enum logic {
    COLLECT = 1'b0,
    PENDING = 1'b1
  } state_t;

endpackage

// File: rtl/result_fifo.sv
// First-word fall-through result buffer with occupancy count.
// Pushes into a full FIFO and pops from an empty one are ignored.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [DW-1:0]              i_data,
  input  logic                       i_pop,
  output logic [DW-1:0]              o_data,
  output logic                       o_valid,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_empty = (r_count == '0);
  assign w_push  = i_push && (r_count != CW'(DEPTH));
  assign w_pop   = i_pop && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is forced to zero while empty so the output is clean straight out of reset.
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_valid = !w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/adder_tree_loader.sv
// Packs a serial operand stream into LANES-wide frames, launches them into the
// external pipelined adder tree under credit control and buffers the returning sums.
module adder_tree_loader
  import adder_tree_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [LANES*W-1:0]   tree_x,
  output logic                 tree_launch,
  input  logic [W-1:0]         tree_sum,
  output logic [W-1:0]         out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     frames_launched
);

  localparam int LW  = $clog2(LANES);
  localparam int FCW = $clog2(RES_DEPTH + 1);
  localparam int CRW = $clog2(RES_DEPTH + TREE_LAT + 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [LW-1:0]       r_count;
  logic [LW-1:0]       w_count_next;
  logic [LANES*W-1:0]  r_frame;
  logic [LANES*W-1:0]  w_frame_next;
  logic [TREE_LAT-1:0] r_vld;
  logic [CNT_W-1:0]    r_launched;
  logic [FCW-1:0]      w_fifo_count;
  logic [CRW-1:0]      w_inflight;
  logic [CRW-1:0]      w_credits_used;
  logic                w_accept;
  logic                w_launch;

  assign w_accept = in_valid && (r_state == COLLECT);

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < TREE_LAT; i++) begin
      w_inflight = w_inflight + CRW'(r_vld[i]);
    end
  end

  // Both terms are registered, so a pop in the launch cycle only frees its credit next cycle.
  assign w_credits_used = w_inflight + CRW'(w_fifo_count);
  assign w_launch       = (r_state == PENDING) && (w_credits_used < CRW'(RES_DEPTH));

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_frame_next = r_frame;
    if (r_state == COLLECT) begin
      if (w_accept) begin
        for (int i = 0; i < LANES; i++) begin
          if (r_count == LW'(i)) begin
            w_frame_next[i*W +: W] = in_data;
          end
        end
        w_count_next = r_count + LW'(1);
        if (in_last || (r_count == LW'(LANES - 1))) begin
          w_state_next = PENDING;
        end
      end
    end else if (w_launch) begin
      // Clearing the frame here is what zero-pads the lanes of a short frame.
      w_state_next = COLLECT;
      w_count_next = '0;
      w_frame_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= COLLECT;
      r_count    <= '0;
      r_frame    <= '0;
      r_vld      <= '0;
      r_launched <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_frame <= w_frame_next;
      for (int i = TREE_LAT - 1; i > 0; i--) begin
        r_vld[i] <= r_vld[i-1];
      end
      r_vld[0]   <= w_launch;
      r_launched <= r_launched + CNT_W'(w_launch);
    end
  end

  result_fifo #(
    .DEPTH (RES_DEPTH),
    .DW    (W)
  ) u_result_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_vld[TREE_LAT-1]),
    .i_data  (tree_sum),
    .i_pop   (out_ready),
    .o_data  (out_data),
    .o_valid (out_valid),
    .o_count (w_fifo_count)
  );

  assign in_ready        = (r_state == COLLECT);
  assign tree_launch     = w_launch;
  assign tree_x          = w_launch ? r_frame : '0;
  assign frames_launched = r_launched;

endmodule

// File: tb/tb_adder_tree_loader.sv
// Randomised bench for adder_tree_loader with a 3-stage tree model and a
// frame/sum scoreboard built from the accepted operand stream.
module tb_adder_tree_loader;
  import adder_tree_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic [W-1:0]        in_data;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  logic [LANES*W-1:0]  tree_x;
  logic                tree_launch;
  logic [W-1:0]        tree_sum;
  logic [W-1:0]        out_data;
  logic                out_valid;
  logic                out_ready;
  logic [CNT_W-1:0]    frames_launched;

  always #5 clk = ~clk;

  adder_tree_loader dut (
    .clk             (clk),
    .rst             (rst),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_last         (in_last),
    .in_ready        (in_ready),
    .tree_x          (tree_x),
    .tree_launch     (tree_launch),
    .tree_sum        (tree_sum),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .frames_launched (frames_launched)
  );

  // Environment model of the external tree: three register stages sharing rst.
  logic [W-1:0] tree_s1, tree_s2, tree_s3;
  logic [W-1:0] tree_in_sum;
  always_comb begin
    tree_in_sum = '0;
    for (int i = 0; i < LANES; i++) tree_in_sum = tree_in_sum + tree_x[i*W +: W];
  end
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tree_s1 <= '0; tree_s2 <= '0; tree_s3 <= '0;
    end else begin
      tree_s1 <= tree_in_sum; tree_s2 <= tree_s1; tree_s3 <= tree_s2;
    end
  end
  assign tree_sum = tree_s3;

  typedef struct packed { logic [7:0] d; logic last; } op_t;

  op_t         src_q[$];
  logic [63:0] frame_q[$];
  logic [7:0]  exp_q[$];
  logic [63:0] cur_frame;
  int          cur_lanes, cur_sum;
  int          total, bad;
  int          cyc, launches, pops;
  int          last_launch_cyc, first_valid_cyc;
  int          launch_cyc_q[$];
  logic [7:0]  last_out;
  logic [63:0] last_tree_x;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic reset_sb();
    src_q.delete(); frame_q.delete(); exp_q.delete(); launch_cyc_q.delete();
    cur_frame = '0; cur_lanes = 0; cur_sum = 0; launches = 0; pops = 0;
  endtask

  task automatic add_frame(input int len, input logic [63:0] bytes, input bit mark_full);
    op_t op;
    for (int i = 0; i < len; i++) begin
      op.d    = bytes[i*8 +: 8];
      op.last = (i == len - 1) && (len < 8 || mark_full);
      src_q.push_back(op);
    end
  endtask

  task automatic observe();
    if (tree_launch) begin
      if (frame_q.size() == 0) check("launch_unexpected", 1, 0);
      else check("tree_x", tree_x, frame_q.pop_front());
      check("credit_limit", 64'(launches - pops + 1 <= RES_DEPTH), 1);
      last_tree_x = tree_x;
      launches++;
      last_launch_cyc = cyc;
      launch_cyc_q.push_back(cyc);
    end else begin
      check("tree_x_idle", tree_x, 0);
    end
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_out", 1, 0);
      else check("out_data", out_data, exp_q.pop_front());
      last_out = out_data;
      pops++;
    end
    if (in_valid && in_ready) begin
      cur_frame[cur_lanes*8 +: 8] = in_data;
      cur_sum += int'(in_data);
      cur_lanes++;
      void'(src_q.pop_front());
      if (in_last || cur_lanes == 8) begin
        frame_q.push_back(cur_frame);
        exp_q.push_back(8'(cur_sum % 256));
        cur_frame = '0; cur_lanes = 0; cur_sum = 0;
      end
    end
  endtask

  task automatic tick(input int vp, input int rp);
    @(negedge clk);
    if (src_q.size() > 0 && $urandom_range(99) < vp) begin
      in_valid = 1'b1; in_data = src_q[0].d; in_last = src_q[0].last;
    end else begin
      in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
    end
    out_ready = ($urandom_range(99) < rp);
    #1;
    observe();
    cyc++;
  endtask

  task automatic wait_idle(input int budget, input int vp, input int rp);
    int n = 0;
    while ((src_q.size() > 0 || frame_q.size() > 0 || exp_q.size() > 0 || out_valid) && n < budget) begin
      tick(vp, rp);
      n++;
    end
    if (n >= budget) check("drain_timeout", 0, 1);
  endtask

  initial begin
    int base, n;
    logic [63:0] fr;
    total = 0; bad = 0; cyc = 0;
    first_valid_cyc = -1; last_launch_cyc = 0; last_out = '0; last_tree_x = '0;
    in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
    reset_sb();
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_tree_launch", tree_launch, 0);
    check("rst_tree_x", tree_x, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_frames", frames_launched, 0);
    @(negedge clk) rst = 1'b0;

    // 1: single frame 1..8
    add_frame(8, 64'h0807060504030201, 1'b1);
    first_valid_cyc = -1;
    wait_idle(100, 100, 100);
    check("t1_sum", last_out, 36);
    check("t1_latency", 64'(first_valid_cyc - last_launch_cyc), 4);
    check("t1_launches", 64'(launches), 1);
    check("t1_frames_launched", frames_launched, 1);

    // 2: back-to-back 0xFF frames
    launch_cyc_q.delete();
    for (int f = 0; f < 3; f++) add_frame(8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wait_idle(200, 100, 100);
    check("t2_sum", last_out, 8'hF8);
    check("t2_nlaunch", 64'(launch_cyc_q.size()), 3);
    if (launch_cyc_q.size() == 3) begin
      check("t2_period_a", 64'(launch_cyc_q[1] - launch_cyc_q[0]), 9);
      check("t2_period_b", 64'(launch_cyc_q[2] - launch_cyc_q[1]), 9);
    end

    // 3: short frame zero-padded
    add_frame(3, 64'h1E140A, 1'b1);
    wait_idle(100, 100, 100);
    check("t3_sum", last_out, 60);
    check("t3_pad", last_tree_x[63:24], 0);
    check("t3_lanes", last_tree_x[23:0], 64'h1E140A);

    // 4: full backpressure, six frames
    base = launches;
    for (int f = 0; f < 6; f++) begin
      fr = {$urandom, $urandom};
      add_frame(8, fr, 1'b0);
    end
    repeat (120) tick(100, 0);
    check("t4_launches_held", 64'(launches - base), 4);
    check("t4_in_ready", in_ready, 0);
    check("t4_out_valid", out_valid, 1);
    if (exp_q.size() > 0) check("t4_head", out_data, exp_q[0]);
    else check("t4_head_missing", 0, 1);
    wait_idle(400, 100, 100);
    check("t4_launches_all", 64'(launches - base), 6);
    check("t4_frames_launched", frames_launched, 64'(launches[15:0]));

    // 5: reset with frames in flight and a partial frame collected
    for (int f = 0; f < 3; f++) add_frame(8, {$urandom, $urandom}, 1'b0);
    base = launches; n = 0;
    while (launches - base < 2 && n < 100) begin tick(100, 100); n++; end
    if (n >= 100) check("t5_wait_timeout", 0, 1);
    repeat (3) tick(100, 100);
    check("t5_partial_lanes", 64'(cur_lanes), 3);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t5_in_ready", in_ready, 1);
    check("t5_tree_launch", tree_launch, 0);
    check("t5_tree_x", tree_x, 0);
    check("t5_out_valid", out_valid, 0);
    check("t5_out_data", out_data, 0);
    check("t5_frames", frames_launched, 0);
    reset_sb();
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(100, 100);
      check("t5_no_valid", out_valid, 0);
    end
    add_frame(5, 64'h05_64_C8_33_07, 1'b1);
    wait_idle(100, 100, 100);
    check("t5_fresh_sum", last_out, 8'((8'h07 + 8'h33 + 8'hC8 + 8'h64 + 8'h05)));
    check("t5_frames_after", frames_launched, 1);

    // 6: random traffic over 200 frames
    base = launches;
    for (int f = 0; f < 200; f++) begin
      n = $urandom_range(1, 8);
      add_frame(n, {$urandom, $urandom}, 1'($urandom));
    end
    wait_idle(20000, 70, 60);
    check("t6_launches", 64'(launches - base), 200);
    check("t6_pops_match", 64'(pops), 64'(launches));
    check("t6_frames_launched", frames_launched, 64'(launches[15:0]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_tree_loader.md
Name: adder_tree_loader

Overview:
Front-end and back-end controller for the pipelined 8-input adder tree.
- Accepts a serial 8-bit operand stream with a valid/ready handshake and packs it into 8-lane frames.
- Launches each frame into the tree for one cycle.
- Tracks in-flight frames through the fixed tree latency and buffers returning sums in a small result FIFO with a valid/ready output.
- Launches are credit-limited, so the non-stallable tree can never overrun the FIFO.

Parameters:
W, 8, operand and sum width; sums wrap modulo 2^W.
LANES, 8, operands per frame, matching the tree input count.
TREE_LAT, 3, cycles from the tree input being sampled to the tree output register being updated.
RES_DEPTH, 4, result FIFO depth; also the total credit count (in flight plus buffered).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_data  in  W  operand byte.
in_valid  in  1  in_data is valid.
in_last  in  1  marks the final operand of a frame; a short frame is zero-padded.
in_ready  out  1  loader accepts an operand this cycle.
tree_x  out  LANES*W  packed operands to the tree; lane i is bits [i*W +: W].
tree_launch  out  1  tree_x carries a valid frame this cycle.
tree_sum  in  W  registered output of the final tree stage.
out_data  out  W  frame sum.
out_valid  out  1  out_data is valid.
out_ready  in  1  consumer accepts out_data.
frames_launched  out  16  free-running count of launched frames; wraps at 2^16.

Behaviour:
- Reset: asynchronous, clears everything.
  - Lane count = 0, frame register = 0, full flag = 0, in-flight shift register = 0, FIFO empty, frames_launched = 0.
  - Outputs: in_ready = 1, tree_launch = 0, tree_x = 0, out_valid = 0, out_data = 0.
  - Reset mid-operation discards all in-flight frames and buffered results. The tree shares rst, so no stale sum is ever captured.
- States: COLLECT (lane count 0..LANES-1, full = 0) and PENDING (full = 1, waiting for credit).
- Accept: an operand is accepted when in_valid & in_ready. in_ready = 1 only in COLLECT.
  - The accepted operand is written to lane[count] and count increments.
  - If count was LANES-1, or in_last = 1, the state moves to PENDING.
  - Lanes above the last written lane are forced to 0 (zero padding). in_last on lane 7 is equivalent to no in_last.
- Launch condition: PENDING & (inflight + fifo_count < RES_DEPTH).
  - Both counts are registered values. A FIFO pop in the same cycle does not free a credit until the next cycle.
  - In the launch cycle: tree_launch = 1, tree_x = frame, frames_launched increments.
  - On the next edge: state → COLLECT, count = 0, frame register cleared.
  - No operand is accepted during the launch cycle (in_ready = 0), so the minimum frame period is LANES+1 cycles.
- tree_x is 0 whenever tree_launch = 0, so tree outputs are deterministic.
- In-flight tracking:
  - A TREE_LAT-bit shift register vld shifts every cycle, with vld[0] <= tree_launch.
  - inflight = popcount(vld). Alternatively, use a counter: +1 on launch, −1 on capture, with simultaneous launch and capture netting 0.
- Capture: while vld[TREE_LAT-1] = 1, tree_sum is pushed into the FIFO at the end of that cycle.
  - Latency: launch in cycle L → FIFO write at end of cycle L+TREE_LAT → out_valid earliest in cycle L+TREE_LAT+1 (L+4 by default).
- FIFO: first-word fall-through; out_data = head; out_valid = !empty; pop on out_valid & out_ready.
  - Simultaneous push and pop when full cannot occur, because credits guarantee a free slot. Simultaneous push and pop at any occupancy keeps the count unchanged.
- Arithmetic: the loader performs none. out_data is the tree's W-bit wrapped sum.
- Backpressure: with out_ready = 0 indefinitely, at most RES_DEPTH frames are launched. The loader then holds in PENDING and in_ready = 0 after the next frame fills.

Decomposition:
- adder_tree_pkg holds the constants LANES = 8, W = 8, TREE_LAT = 3 and the state encoding (COLLECT, PENDING).
- One natural sub-module: result_fifo (synchronous, first-word fall-through, depth RES_DEPTH, width W, async active-high reset).
- Packing, credit and launch logic stay in the top.

Test Plan:
1. Reset release, then stream 1,2,…,8 with out_ready = 1 → tree_launch pulses once with lane i = i+1. out_data = 36 with out_valid in launch cycle + 4. frames_launched = 1.
2. Eight operands of 0xFF → out_data = 0xF8 (2040 mod 256). Back-to-back frames launch every 9 cycles with in_valid held high.
3. Operands 10, 20, 30 with in_last on 30 → lanes 3..7 = 0 in tree_x; out_data = 60.
4. out_ready = 0, stream 6 full frames → exactly 4 launches. in_ready then stays 0 and out_valid = 1 with the first sum. Set out_ready = 1: sums drain in order and the remaining frames launch. The credit count never exceeds 4.
5. Assert rst while two frames are in flight and 3 lanes are collected → next cycle all outputs are at reset values and no out_valid appears. A fresh frame then produces a correct sum.
6. Random in_valid and out_ready toggling over 200 frames → every out_data matches the scoreboard sum mod 256, in order, with no loss or duplication.
